// File: rtl/xlr8_tone_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : xlr8_tone_gen                                                 |
// | Purpose  : NCHAN-channel saw/square/triangle tone generator on the XLR8  |
// |            data-memory bus, mixed and volume-attenuated into a sample    |
// |            stream with a one-cycle valid strobe.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module xlr8_tone_gen #(
  parameter int         NCHAN           = 4,
  parameter int         AUDIO_BIT_WIDTH = 16,
  parameter int         PHASE_W         = 24,
  parameter int         CLK_HZ          = 16000000,
  parameter int         AUDIO_RATE      = 48000,
  parameter int         TICK_CYCLES     = 1000000,
  parameter logic [7:0] CHAN_SEL_ADDR   = 8'hE0,
  parameter logic [7:0] MODE_ADDR       = 8'hE1,
  parameter logic [7:0] RATE_ADDR       = 8'hE2,
  parameter logic [7:0] DUR_ADDR        = 8'hE3,
  parameter logic [7:0] VOLUME_ADDR     = 8'hE4,
  parameter logic [7:0] STATUS_ADDR     = 8'hE5
) (
  input  logic                       clk_core,
  input  logic                       rst,
  input  logic                       clken,
  input  logic [7:0]                 dbus_in,
  output logic [7:0]                 dbus_out,
  output logic                       io_out_en,
  input  logic [7:0]                 ramadr,
  input  logic                       ramre,
  input  logic                       ramwe,
  input  logic                       dm_sel,
  output logic [AUDIO_BIT_WIDTH-1:0] audio_out,
  output logic                       audio_valid,
  output logic [NCHAN-1:0]           busy
);

  // Channel-select storage is at least one bit wide so NCHAN=1 still elaborates.
  localparam int          c_sel_w   = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int          c_log2n   = $clog2(NCHAN);
  localparam int          c_mix_w   = AUDIO_BIT_WIDTH + c_log2n;
  localparam int          c_div     = CLK_HZ / AUDIO_RATE;
  localparam int          c_div_w   = (c_div > 1) ? $clog2(c_div) : 1;
  localparam int          c_cnt_w   = $clog2(255 * TICK_CYCLES + 1);
  localparam logic [63:0] c_k       = (64'd8 << PHASE_W) / 64'(AUDIO_RATE);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(c_div - 1);
  localparam logic [c_cnt_w-1:0] c_tick     = c_cnt_w'(TICK_CYCLES);
  localparam logic [5:0]         c_aw       = 6'(AUDIO_BIT_WIDTH);

  // Register state
  logic [c_sel_w-1:0]         chan_sel_q, chan_sel_d;
  logic [1:0]                 mode_q  [NCHAN];
  logic [1:0]                 mode_d  [NCHAN];
  logic [7:0]                 rate_q  [NCHAN];
  logic [7:0]                 rate_d  [NCHAN];
  logic [c_cnt_w-1:0]         cnt_q   [NCHAN];
  logic [c_cnt_w-1:0]         cnt_d   [NCHAN];
  logic [PHASE_W-1:0]         phase_q [NCHAN];
  logic [PHASE_W-1:0]         phase_d [NCHAN];
  logic [7:0]                 vol_q, vol_d;
  logic [NCHAN-1:0]           busy_q, busy_d;
  logic [c_div_w-1:0]         div_q, div_d;
  logic                       tick_q, tick_d;
  logic [AUDIO_BIT_WIDTH-1:0] audio_out_q, audio_out_d;
  logic                       audio_valid_q, audio_valid_d;

  // Combinational helpers
  logic                       w_sel_chan, w_sel_mode, w_sel_rate, w_sel_dur, w_sel_vol, w_sel_stat;
  logic                       w_wr, w_tick;
  logic [c_cnt_w-1:0]         w_dur_load;
  logic [AUDIO_BIT_WIDTH-1:0] w_wave;
  logic [c_mix_w-1:0]         w_mix;
  logic [AUDIO_BIT_WIDTH-1:0] w_avg, w_att;
  logic [7:0]                 w_chan_rd, w_status, w_rd;

  assign w_sel_chan = dm_sel && (ramadr == CHAN_SEL_ADDR);
  assign w_sel_mode = dm_sel && (ramadr == MODE_ADDR);
  assign w_sel_rate = dm_sel && (ramadr == RATE_ADDR);
  assign w_sel_dur  = dm_sel && (ramadr == DUR_ADDR);
  assign w_sel_vol  = dm_sel && (ramadr == VOLUME_ADDR);
  assign w_sel_stat = dm_sel && (ramadr == STATUS_ADDR);
  assign w_wr       = ramwe && clken;
  assign w_tick     = (div_q == c_div_last);
  assign w_dur_load = c_cnt_w'(dbus_in) * c_tick;

  // Zero-extended views of channel select and busy for bus reads
  always_comb begin
    w_chan_rd = '0;
    w_status  = '0;
    if (NCHAN > 1) begin
      w_chan_rd[c_sel_w-1:0] = chan_sel_q;
    end
    w_status[NCHAN-1:0] = busy_q;
  end

  // Read mux: OR of every selected register's value
  always_comb begin
    w_rd = '0;
    if (w_sel_chan) w_rd = w_rd | w_chan_rd;
    if (w_sel_mode) w_rd = w_rd | {6'b0, mode_q[chan_sel_q]};
    if (w_sel_rate) w_rd = w_rd | rate_q[chan_sel_q];
    if (w_sel_dur)  w_rd = w_rd | {7'b0, busy_q[chan_sel_q]};
    if (w_sel_vol)  w_rd = w_rd | vol_q;
    if (w_sel_stat) w_rd = w_rd | w_status;
  end

  assign dbus_out  = w_rd;
  assign io_out_en = ramre && (w_sel_chan || w_sel_mode || w_sel_rate ||
                               w_sel_dur  || w_sel_vol  || w_sel_stat);

  // Per-channel waveform, average over channels, then volume shift
  always_comb begin
    w_mix  = '0;
    w_wave = '0;
    for (int i = 0; i < NCHAN; i++) begin
      w_wave = '0;
      if (busy_q[i]) begin
        case (mode_q[i])
          2'b00:   w_wave = phase_q[i][PHASE_W-1 -: AUDIO_BIT_WIDTH];
          2'b01:   w_wave = {AUDIO_BIT_WIDTH{phase_q[i][PHASE_W-1]}};
          2'b10:   w_wave = phase_q[i][PHASE_W-1] ? ~phase_q[i][PHASE_W-2 -: AUDIO_BIT_WIDTH]
                                                  :  phase_q[i][PHASE_W-2 -: AUDIO_BIT_WIDTH];
          default: w_wave = '0;
        endcase
      end
      w_mix = w_mix + c_mix_w'(w_wave);
    end
    w_avg = AUDIO_BIT_WIDTH'(w_mix >> c_log2n);
    w_att = ({1'b0, vol_q[4:0]} >= c_aw) ? '0 : (w_avg >> vol_q[4:0]);
  end

  // Next-state: bus writes, duration countdown, phase advance, sample pipeline
  always_comb begin
    chan_sel_d = chan_sel_q;
    mode_d     = mode_q;
    rate_d     = rate_q;
    vol_d      = vol_q;
    for (int i = 0; i < NCHAN; i++) begin
      cnt_d[i]   = (cnt_q[i] != '0) ? cnt_q[i] - 1'b1 : '0;
      // inc is derived from the current rate, so a same-edge RATE write is not seen yet
      phase_d[i] = (w_tick && busy_q[i])
                 ? phase_q[i] + PHASE_W'(64'(rate_q[i]) * c_k)
                 : phase_q[i];
      busy_d[i]  = (cnt_q[i] != '0);
    end
    if (w_sel_chan && w_wr) chan_sel_d = (NCHAN > 1) ? dbus_in[c_sel_w-1:0] : '0;
    if (w_sel_mode && w_wr) mode_d[chan_sel_q] = dbus_in[1:0];
    if (w_sel_rate && w_wr) rate_d[chan_sel_q] = dbus_in;
    // A DUR write overrides the countdown, so a reload on the last cycle keeps busy high
    if (w_sel_dur && w_wr) begin
      cnt_d[chan_sel_q]   = w_dur_load;
      phase_d[chan_sel_q] = '0;
    end
    if (w_sel_vol && w_wr) vol_d = dbus_in;
    div_d         = w_tick ? '0 : div_q + 1'b1;
    tick_d        = w_tick;
    audio_valid_d = tick_q;
    audio_out_d   = tick_q ? w_att : audio_out_q;
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk_core or posedge rst) begin
    if (rst) begin
      chan_sel_q    <= '0;
      vol_q         <= '0;
      busy_q        <= '0;
      div_q         <= '0;
      tick_q        <= 1'b0;
      audio_out_q   <= '0;
      audio_valid_q <= 1'b0;
      for (int i = 0; i < NCHAN; i++) begin
        mode_q[i]  <= '0;
        rate_q[i]  <= '0;
        cnt_q[i]   <= '0;
        phase_q[i] <= '0;
      end
    end else begin
      chan_sel_q    <= chan_sel_d;
      vol_q         <= vol_d;
      busy_q        <= busy_d;
      div_q         <= div_d;
      tick_q        <= tick_d;
      audio_out_q   <= audio_out_d;
      audio_valid_q <= audio_valid_d;
      for (int i = 0; i < NCHAN; i++) begin
        mode_q[i]  <= mode_d[i];
        rate_q[i]  <= rate_d[i];
        cnt_q[i]   <= cnt_d[i];
        phase_q[i] <= phase_d[i];
      end
    end
  end

  assign audio_out   = audio_out_q;
  assign audio_valid = audio_valid_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_xlr8_tone_gen.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_xlr8_tone_gen                                              |
// | Purpose  : Scoreboard bench for xlr8_tone_gen (DIV=33, TICK_CYCLES=10).  |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_xlr8_tone_gen;

  localparam int         DIV    = 33;   // 1600000 / 48000
  localparam logic [7:0] A_CHAN = 8'h40;
  localparam logic [7:0] A_MODE = 8'h41;
  localparam logic [7:0] A_RATE = 8'h42;
  localparam logic [7:0] A_DUR  = 8'h43;
  localparam logic [7:0] A_VOL  = 8'h44;
  localparam logic [7:0] A_STAT = 8'h45;
  localparam logic [7:0] A_NONE = 8'h50;

  logic        clk = 1'b0;
  logic        rst, clken, ramre, ramwe, dm_sel;
  logic [7:0]  dbus_in, ramadr, dbus_out;
  logic        io_out_en;
  logic [15:0] audio_out;
  logic        audio_valid;
  logic [3:0]  busy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic        chk;
    logic [15:0] val;
    logic [15:0] tag;
  } exp_t;
  exp_t sbq[$];

  xlr8_tone_gen #(
    .NCHAN(4), .AUDIO_BIT_WIDTH(16), .PHASE_W(24), .CLK_HZ(1600000),
    .AUDIO_RATE(48000), .TICK_CYCLES(10),
    .CHAN_SEL_ADDR(A_CHAN), .MODE_ADDR(A_MODE), .RATE_ADDR(A_RATE),
    .DUR_ADDR(A_DUR), .VOLUME_ADDR(A_VOL), .STATUS_ADDR(A_STAT)
  ) dut (
    .clk_core(clk), .rst(rst), .clken(clken), .dbus_in(dbus_in),
    .dbus_out(dbus_out), .io_out_en(io_out_en), .ramadr(ramadr),
    .ramre(ramre), .ramwe(ramwe), .dm_sel(dm_sel),
    .audio_out(audio_out), .audio_valid(audio_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: each output sample consumes one scoreboard entry when any are queued
  always @(negedge clk) begin
    exp_t e;
    if (!rst && audio_valid && sbq.size() > 0) begin
      e = sbq.pop_front();
      if (e.chk) begin
        n_checks++;
        if (audio_out !== e.val) begin
          n_fail++;
          $display("FAIL sample tag %0d: audio_out=0x%0h required 0x%0h", e.tag, audio_out, e.val);
        end
      end
    end
  end

  task automatic push(input logic c, input logic [15:0] v, input logic [15:0] t);
    exp_t e;
    e.chk = c; e.val = v; e.tag = t;
    sbq.push_back(e);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    dm_sel = 1'b1; ramadr = a; dbus_in = d; ramwe = 1'b1; clken = 1'b1;
    @(posedge clk); #1;
    dm_sel = 1'b0; ramwe = 1'b0; clken = 1'b0; ramadr = 8'h00;
  endtask

  task automatic rd_chk(input string name, input logic [7:0] a, input logic [7:0] exp);
    dm_sel = 1'b1; ramadr = a; ramre = 1'b1; #1;
    check(name, {24'b0, dbus_out}, {24'b0, exp});
    check({name, "_en"}, {31'b0, io_out_en}, 32'd1);
    dm_sel = 1'b0; ramre = 1'b0; ramadr = 8'h00; #1;
  endtask

  task automatic tone(input int ch, input logic [1:0] m, input logic [7:0] r, input logic [7:0] d);
    wr(A_CHAN, 8'(ch)); wr(A_MODE, {6'b0, m}); wr(A_RATE, r); wr(A_DUR, d);
  endtask

  task automatic stop_all();
    for (int ch = 0; ch < 4; ch++) begin
      wr(A_CHAN, 8'(ch)); wr(A_DUR, 8'h00);
    end
  endtask

  // Return at the negedge where a sample is presented: the next tick is DIV-1 cycles away
  task automatic sync_valid();
    int n = 0;
    @(negedge clk);
    while (!audio_valid && n < 200) begin @(negedge clk); n++; end
    check("sync_valid", {31'b0, audio_valid}, 32'd1);
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() > 0 && n < 2000) begin @(negedge clk); n++; end
    check("drain", sbq.size(), 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; clken = 1'b0; ramre = 1'b0; ramwe = 1'b0; dm_sel = 1'b0;
    dbus_in = 8'h00; ramadr = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_busy", {28'b0, busy}, 32'd0);
    check("rst_audio", {16'b0, audio_out}, 32'd0);
    check("rst_valid", {31'b0, audio_valid}, 32'd0);
    check("rst_dbus", {24'b0, dbus_out}, 32'd0);
    check("rst_en", {31'b0, io_out_en}, 32'd0);
    @(negedge clk); rst = 1'b0;

    // Saw on channel 0, rate 55: phase 0x258B4 then 0x4B168
    sync_valid();
    wr(A_VOL, 8'h00);
    tone(0, 2'b00, 8'd55, 8'd255);
    push(1'b1, 16'h0096, 16'd1);
    push(1'b1, 16'h012C, 16'd2);
    drain();

    // Volume: halving, then two full-mute settings
    sync_valid();
    wr(A_VOL, 8'h01);
    tone(0, 2'b00, 8'd55, 8'd255);
    push(1'b1, 16'h004B, 16'd11);
    push(1'b1, 16'h0096, 16'd12);
    drain();
    sync_valid();
    wr(A_VOL, 8'd16);
    tone(0, 2'b00, 8'd55, 8'd255);
    push(1'b1, 16'h0000, 16'd13);
    drain();
    sync_valid();
    wr(A_VOL, 8'hF0);
    tone(0, 2'b00, 8'd55, 8'd255);
    push(1'b1, 16'h0000, 16'd14);
    drain();
    wr(A_VOL, 8'h00);
    stop_all();

    // Square on channel 1, inc 0xAE114: MSB first set after 12 ticks (0x828CF0)
    sync_valid();
    tone(1, 2'b01, 8'd255, 8'd255);
    for (int k = 1; k <= 12; k++)
      push((k == 1) || (k >= 11), (k == 12) ? 16'h3FFF : 16'h0000, 16'(100 + k));
    drain();
    stop_all();

    // Triangle on channel 2: phase 0x414678 -> w 0x828C, phase 0xC3D368 -> w 0x7859
    sync_valid();
    tone(2, 2'b10, 8'd255, 8'd255);
    for (int k = 1; k <= 18; k++)
      push((k == 6) || (k == 18), (k == 6) ? 16'h20A3 : 16'h1E16, 16'(200 + k));
    drain();
    stop_all();

    // All four channels square, same phase: full-scale once MSB is set
    sync_valid();
    for (int ch = 0; ch < 4; ch++) tone(ch, 2'b01, 8'd255, 8'd255);
    for (int k = 1; k <= 12; k++)
      push(k >= 11, (k == 12) ? 16'hFFFF : 16'h0000, 16'(300 + k));
    drain();
    stop_all();

    // Mode off silences a channel that would otherwise produce 0x02B8
    sync_valid();
    tone(0, 2'b11, 8'd255, 8'd255);
    push(1'b1, 16'h0000, 16'd401);
    push(1'b1, 16'h0000, 16'd402);
    drain();
    stop_all();

    // Sample spacing
    sync_valid();
    cnt = 0;
    do begin @(negedge clk); cnt++; end while (!audio_valid && cnt < 100);
    check("valid_spacing", cnt, DIV);

    // Duration: DUR=3 holds busy for 30 cycles
    repeat (2) @(posedge clk);
    #1;
    wr(A_CHAN, 8'h00);
    wr(A_DUR, 8'd3);
    cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (busy[0]) cnt++;
      if (c == 5) begin
        rd_chk("status_busy", A_STAT, 8'h01);
        rd_chk("dur_read_busy", A_DUR, 8'h01);
      end
    end
    check("busy_cycles", cnt, 30);
    rd_chk("status_idle", A_STAT, 8'h00);

    // DUR=0 mid-tone: busy drops one cycle after the write
    wr(A_DUR, 8'd3);
    repeat (5) begin @(posedge clk); #1; end
    wr(A_DUR, 8'd0);
    @(posedge clk); #1;
    check("dur0_stop", {31'b0, busy[0]}, 32'd0);

    // Reload on the cycle the counter would hit zero keeps busy high
    wr(A_DUR, 8'd1);
    cnt = 0;
    repeat (9) begin @(posedge clk); #1; if (!busy[0]) cnt++; end
    wr(A_DUR, 8'd1);
    if (!busy[0]) cnt++;
    repeat (5) begin @(posedge clk); #1; if (!busy[0]) cnt++; end
    check("reload_no_drop", cnt, 0);
    stop_all();

    // Bus decode
    wr(A_CHAN, 8'hFF);
    rd_chk("chan_sel_ff", A_CHAN, 8'h03);
    dm_sel = 1'b1; ramadr = A_VOL; dbus_in = 8'h55; ramwe = 1'b1; clken = 1'b0;
    @(posedge clk); #1;
    dm_sel = 1'b0; ramwe = 1'b0;
    rd_chk("clken0_ignored", A_VOL, 8'h00);
    dm_sel = 1'b1; ramadr = A_NONE; ramre = 1'b1; #1;
    check("unmapped_dbus", {24'b0, dbus_out}, 32'd0);
    check("unmapped_en", {31'b0, io_out_en}, 32'd0);
    ramadr = A_STAT; ramre = 1'b0; #1;
    check("no_re_en", {31'b0, io_out_en}, 32'd0);
    dm_sel = 1'b0; ramre = 1'b1; #1;
    check("no_sel_en", {31'b0, io_out_en}, 32'd0);
    ramre = 1'b0; ramadr = 8'h00;

    // Reset mid-tone, then first sample DIV+1 cycles after release
    wr(A_CHAN, 8'h00);
    sync_valid();
    tone(0, 2'b00, 8'd255, 8'd255);
    push(1'b1, 16'h02B8, 16'd501);
    drain();
    wr(A_VOL, 8'h07);
    @(posedge clk); #3;
    rst = 1'b1; #1;
    check("rst_mid_busy", {28'b0, busy}, 32'd0);
    check("rst_mid_audio", {16'b0, audio_out}, 32'd0);
    rd_chk("rst_rd_chan", A_CHAN, 8'h00);
    rd_chk("rst_rd_mode", A_MODE, 8'h00);
    rd_chk("rst_rd_rate", A_RATE, 8'h00);
    rd_chk("rst_rd_dur", A_DUR, 8'h00);
    rd_chk("rst_rd_vol", A_VOL, 8'h00);
    rd_chk("rst_rd_stat", A_STAT, 8'h00);
    @(negedge clk); #1;
    rst = 1'b0;
    cnt = 0;
    do begin @(posedge clk); #1; cnt++; end while (!audio_valid && cnt < 200);
    check("first_valid_after_rst", cnt, DIV + 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
